// File: rtl/alu_modport_if.sv
// ALU bus: operands, opcode and valid flow from master to the ALU; the
// registered result/flag word flows back.
interface alu_modport_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] i;
  logic       v;
  logic [5:0] s;

  modport master (output a, output b, output i, output v, input s);
  modport slave  (input a, input b, input i, input v, output s);
endinterface

// File: rtl/alu_modport.sv
// Registered 4-bit ALU: accepts one op per cycle when valid is high and holds
// {zero, value[4:0]} on the bus until the next accepted op.
module alu_modport (
  input  logic          clk,
  input  logic          rst_n,
  alu_modport_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_INC  = 4'h2, OP_DEC  = 4'h3,
    OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_NOT  = 4'h7,
    OP_NAND = 4'h8, OP_NOR  = 4'h9, OP_XNOR = 4'hA, OP_SHL  = 4'hB,
    OP_SHR  = 4'hC, OP_ROL  = 4'hD, OP_ROR  = 4'hE, OP_CMP  = 4'hF
  } op_e;

  op_e        op;
  logic [4:0] a_ext;
  logic [4:0] b_ext;
  logic [4:0] r;
  logic [5:0] s_d;
  logic [5:0] s_q;

  assign op    = op_e'(bus.i);
  assign a_ext = {1'b0, bus.a};
  assign b_ext = {1'b0, bus.b};

  // Arithmetic is done at 5 bits so bit 4 naturally carries the carry/borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r = '0;
    case (op)
      OP_ADD:  r = a_ext + b_ext;
      OP_SUB:  r = a_ext - b_ext;
      OP_INC:  r = a_ext + 5'd1;
      OP_DEC:  r = a_ext - 5'd1;
      OP_AND:  r = {1'b0, bus.a & bus.b};
      OP_OR:   r = {1'b0, bus.a | bus.b};
      OP_XOR:  r = {1'b0, bus.a ^ bus.b};
      OP_NOT:  r = {1'b0, ~bus.a};
      OP_NAND: r = {1'b0, ~(bus.a & bus.b)};
      OP_NOR:  r = {1'b0, ~(bus.a | bus.b)};
      OP_XNOR: r = {1'b0, ~(bus.a ^ bus.b)};
      OP_SHL:  r = {bus.a[3], bus.a[2:0], 1'b0};
      OP_SHR:  r = {bus.a[0], 1'b0, bus.a[3:1]};
      OP_ROL:  r = {1'b0, bus.a[2:0], bus.a[3]};
      OP_ROR:  r = {1'b0, bus.a[0], bus.a[3:1]};
      OP_CMP:  r = {2'b00, bus.a < bus.b, bus.a > bus.b, bus.a == bus.b};
    endcase
  end

  assign s_d = bus.v ? {(r == 5'd0), r} : s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign bus.s = s_q;

endmodule

// File: tb/tb_alu_modport.sv
// Scoreboard bench for alu_modport: expected words are queued when an op is
// driven and compared one cycle later on the falling edge.
module tb_alu_modport;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  alu_modport_if bus ();

  alu_modport dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  sb_entry_t  sb_q[$];
  logic [5:0] last_exp = 6'h00;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got s=%h expected s=%h", tag, got, exp);
    end
  endtask

  // Independent integer model of the opcode table.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int ua = int'(a);
    int ub = int'(b);
    int r;
    logic [4:0] r5;
    case (op)
      4'h0: r = ua + ub;
      4'h1: r = ua - ub + 32;
      4'h2: r = ua + 1;
      4'h3: r = ua + 31;
      4'h4: r = ua & ub;
      4'h5: r = ua | ub;
      4'h6: r = ua ^ ub;
      4'h7: r = 15 - ua;
      4'h8: r = 15 - (ua & ub);
      4'h9: r = 15 - (ua | ub);
      4'hA: r = 15 - (ua ^ ub);
      4'hB: r = ua * 2;
      4'hC: r = (ua / 2) + (ua % 2) * 16;
      4'hD: r = ((ua * 2) % 16) + (ua / 8);
      4'hE: r = (ua / 2) + (ua % 2) * 8;
      default: r = (ua < ub ? 4 : 0) + (ua > ub ? 2 : 0) + (ua == ub ? 1 : 0);
    endcase
    r  = r % 32;
    r5 = r[4:0];
    return {(r5 == 5'd0), r5};
  endfunction

  // One cycle: check the word produced by the previous posedge, then drive the next op.
  task automatic step(input logic vv, input logic [3:0] aa, input logic [3:0] bb,
                      input logic [3:0] ii, input string tag);
    sb_entry_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      last_exp = e.exp;
      check(e.tag, bus.s, e.exp);
    end else begin
      check("hold", bus.s, last_exp);
    end
    bus.v = vv;
    bus.a = aa;
    bus.b = bb;
    bus.i = ii;
    if (vv) begin
      e.tag = tag;
      e.exp = model(aa, bb, ii);
      sb_q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.v = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    bus.i = 4'h0;
    #3;
    check("reset_init", bus.s, 6'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with carry, then hold for five cycles under random idle inputs.
    step(1'b1, 4'hF, 4'h1, 4'h0, "add_carry");
    for (int k = 0; k < 5; k++)
      step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), "idle");
    check("add_carry_held", bus.s, 6'h10);

    // Directed ops back-to-back.
    step(1'b1, 4'h3, 4'h5, 4'h1, "sub_borrow");
    step(1'b1, 4'h5, 4'h5, 4'h1, "sub_zero");
    step(1'b1, 4'hA, 4'h5, 4'h4, "and_zero");
    step(1'b1, 4'h9, 4'h0, 4'hB, "shl");
    step(1'b1, 4'h9, 4'h0, 4'hE, "ror");
    step(1'b1, 4'h7, 4'h7, 4'hF, "cmp_eq");
    step(1'b1, 4'h2, 4'h9, 4'hF, "cmp_lt");
    step(1'b1, 4'h0, 4'h0, 4'h3, "dec_borrow");
    step(1'b1, 4'hF, 4'h0, 4'h2, "inc_carry");

    // Opcode sweeps with two operand patterns.
    for (int op = 0; op < 16; op++)
      step(1'b1, 4'hC, 4'h5, 4'(op), $sformatf("sweep_c5_op%0h", op));
    for (int op = 0; op < 16; op++)
      step(1'b1, 4'h0, 4'hF, 4'(op), $sformatf("sweep_0f_op%0h", op));

    // Random traffic with sparse valid.
    for (int k = 0; k < 60; k++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
           $sformatf("rand%0d", k));

    // Mid-stream reset: result 6'h1E must clear asynchronously and a sampled op is discarded.
    step(1'b1, 4'h3, 4'h5, 4'h1, "pre_reset_sub");
    step(1'b0, 4'h0, 4'h0, 4'h0, "idle");
    check("pre_reset_value", bus.s, 6'h1E);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", bus.s, 6'h00);
    bus.v = 1'b1;
    bus.a = 4'hF;
    bus.b = 4'h1;
    bus.i = 4'h0;
    @(posedge clk);
    #1;
    check("reset_discard", bus.s, 6'h00);
    sb_q.delete();
    last_exp = 6'h00;
    bus.v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 4'h2, 4'h3, 4'h0, "first_after_reset");
    step(1'b0, 4'h0, 4'h0, 4'h0, "idle");
    step(1'b0, 4'h0, 4'h0, 4'h0, "idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
